// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one word read per instruction over the
// req/addr_ok/data_ok bridge port and presents the result to decode under valid/allowin.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        id_allowin,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  input  logic        br_taken,
  input  logic [31:0] br_target
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] tgt, tgt_nxt;
  logic        cancel, cancel_nxt;
  logic        fs_valid_nxt;
  logic [31:0] fs_pc_nxt, fs_inst_nxt;

  assign inst_req   = (state == S_REQ);
  assign inst_addr  = pc;
  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wdata = 32'd0;

  always_comb begin
    // NOTE: every signal driven here gets its hold value first, so no path can infer a latch.
    state_nxt    = state;
    pc_nxt       = pc;
    tgt_nxt      = tgt;
    cancel_nxt   = cancel;
    fs_valid_nxt = fs_valid;
    fs_pc_nxt    = fs_pc;
    fs_inst_nxt  = fs_inst;

    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
        if (br_taken) pc_nxt = br_target;
      end

      S_REQ: begin
        if (inst_addr_ok) begin
          state_nxt = S_WAIT;
          // Accepted this cycle: the address is committed, so a redirect must drain it.
          if (br_taken) begin
            cancel_nxt = 1'b1;
            tgt_nxt    = br_target;
          end
        end else if (br_taken) begin
          pc_nxt = br_target;
        end
      end

      S_WAIT: begin
        if (br_taken) begin
          cancel_nxt = 1'b1;
          tgt_nxt    = br_target;
        end
        if (inst_data_ok) begin
          // A redirect arriving with the data still kills it; the newest target wins.
          if (cancel || br_taken) begin
            pc_nxt     = br_taken ? br_target : tgt;
            cancel_nxt = 1'b0;
            state_nxt  = S_REQ;
          end else begin
            fs_inst_nxt  = inst_rdata;
            fs_pc_nxt    = pc;
            fs_valid_nxt = 1'b1;
            pc_nxt       = pc + 32'd4;
            state_nxt    = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (br_taken) begin
          fs_valid_nxt = 1'b0;
          pc_nxt       = br_target;
          state_nxt    = S_REQ;
        end else if (id_allowin) begin
          fs_valid_nxt = 1'b0;
          state_nxt    = S_REQ;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      tgt      <= 32'd0;
      cancel   <= 1'b0;
      fs_valid <= 1'b0;
      fs_pc    <= 32'd0;
      fs_inst  <= 32'd0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      tgt      <= tgt_nxt;
      cancel   <= cancel_nxt;
      fs_valid <= fs_valid_nxt;
      fs_pc    <= fs_pc_nxt;
      fs_inst  <= fs_inst_nxt;
    end
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction-fetch stage sitting directly upstream of the CPU's AXI bridge, on its instruction sram-like port. Owns the PC, issues one 32-bit read per instruction through the req / addr_ok / data_ok handshake, and presents each fetched instruction with its PC to the decode stage under a valid/allowin handshake. Handles branch redirects at any point in a transaction, discarding in-flight fetches without breaking the bridge's one-outstanding-request protocol.

## Interface
- RESET_PC, 32'hbfc0_0000, first fetch address after reset.
- clk  input  1  system clock, all state on rising edge.
- resetn  input  1  reset; asynchronous, active-low.
- inst_req  output  1  read request to the bridge.
- inst_wr  output  1  constant 0.
- inst_size  output  2  constant 2'b10 (word).
- inst_addr  output  32  fetch address (current PC).
- inst_wdata  output  32  constant 0.
- inst_addr_ok  input  1  bridge accepted request (registered, may lag req by many cycles).
- inst_data_ok  input  1  read data valid; level may persist after the transfer.
- inst_rdata  input  32  read data, valid when inst_data_ok sampled in WAIT.
- id_allowin  input  1  decode can accept an instruction this cycle.
- fs_valid  output  1  fs_pc/fs_inst hold a valid instruction.
- fs_pc  output  32  PC of presented instruction.
- fs_inst  output  32  presented instruction word.
- br_taken  input  1  redirect strobe, one cycle.
- br_target  input  32  redirect target, word-aligned by producer.

## Operation
- States: IDLE, REQ, WAIT, HOLD. Registers: pc, cancel, tgt.
- inst_req = (state==REQ); inst_addr = pc, stable from REQ entry until data_ok is consumed in WAIT.
- IDLE: entered only via reset; next cycle -> REQ.
- REQ: if inst_addr_ok -> WAIT (inst_req drops next cycle). Else stay.
- WAIT: inst_addr_ok ignored. inst_data_ok sampled only here, exactly one consumption per accepted request.
  - data_ok & !cancel -> fs_inst<=inst_rdata, fs_pc<=pc, fs_valid<=1, pc<=pc+4, -> HOLD.
  - data_ok & cancel -> data discarded, pc<=tgt, cancel<=0, -> REQ.
- HOLD: fs_valid=1. id_allowin -> fs_valid<=0, -> REQ (pc already advanced). Else stay.
- Redirect (br_taken), by state:
  - REQ, inst_addr_ok low: pc<=br_target, stay REQ (not yet accepted, retarget is legal).
  - REQ with inst_addr_ok high, or WAIT: cancel<=1, tgt<=br_target; transaction drains, result discarded.
  - HOLD: fs_valid<=0, pc<=br_target, -> REQ; overrides id_allowin (instruction not delivered).
  - IDLE: pc<=br_target.
  - Second redirect while cancel=1 overwrites tgt (last wins).
- pc+4 wraps modulo 2^32 (32'hffff_fffc -> 0).

## Timing
- Reset values: state=IDLE, pc=RESET_PC, cancel=0, tgt=0, inst_req=0, inst_addr=RESET_PC, fs_valid=0, fs_pc=0, fs_inst=0.
- Reset asserted mid-transaction: all registers return to reset values immediately; no handshake completion required.
- First inst_req high in the 2nd cycle after resetn rises.
- Zero-wait bridge loop (addr_ok 1 cycle after req, data_ok 3 cycles after addr_ok, allowin=1): REQ(2) + WAIT(3) + HOLD(1) per instruction.
- fs_valid/fs_pc/fs_inst registered; change only on WAIT->HOLD or HOLD exit.
- fs_valid high => fs_pc/fs_inst stable until id_allowin or br_taken.
- At most one request outstanding; inst_req never high in WAIT or HOLD.

## Test plan
- Reset release, bridge acks after 1 cycle, data_ok 3 cycles later with 32'h2400_0001, allowin=1 -> fs_valid with fs_pc=bfc0_0000, fs_inst=2400_0001; next inst_addr=bfc0_0004.
- id_allowin low 5 cycles in HOLD -> fs_* stable, inst_req stays 0; allowin high -> fs_valid drops next cycle, req for next PC.
- Bridge busy with data 10 cycles, br_taken=1 target 8000_0100 while REQ unaccepted -> inst_addr=8000_0100 next cycle, only that address fetched.
- br_taken in WAIT, target 8000_0200 -> old data_ok consumed silently (fs_valid stays 0), next request at 8000_0200; two redirects in WAIT -> last target fetched.
- br_taken in HOLD with allowin=1 simultaneously -> instruction not delivered, fs_valid=0, next req at target.
- resetn low mid-WAIT -> all outputs at reset values same cycle; after release fetch restarts at bfc0_0000; pc=ffff_fffc fetch -> next inst_addr=0.
